// File: rtl/outpass_pkg.sv
// Shared definitions for the output-pass frame-config mux.
// Holds the per-channel 2-bit mode encodings and the legal delay-line depth range.
package outpass_pkg;

  // Per-channel mode encodings, taken from ConfigBits[2k+1:2k].
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_REG    = 2'b01;
  localparam logic [1:0] MODE_DELAY  = 2'b10;
  localparam logic [1:0] MODE_EDGE   = 2'b11;

  // Legal range for the DELAY-mode shift chain length.
  localparam int unsigned DEPTH_MIN = 2;
  localparam int unsigned DEPTH_MAX = 8;

endpackage

// File: rtl/cus_mux21.sv
// Custom 2:1 mux cell used on the channel output select path.
// Ports:
//   A0 - data selected when S=0
//   A1 - data selected when S=1
//   S  - select
//   X  - mux output
module cus_mux21 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);

  assign X = S ? A1 : A0;

endmodule

// File: rtl/outpass_chan.sv
// One output-pass channel: DEPTH-stage shift chain, rising-edge pulse register and a
// two-level cus_mux21 tree selecting BYPASS / REG / DELAY / EDGE.
// Ports:
//   UserCLK - clock
//   UserRST - synchronous active-high reset, clears chain and edge register
//   CE      - clock enable for all registers of this channel
//   dIn     - fabric-side data bit
//   mode    - 2-bit mode select
//   dOut    - selected output bit
module outpass_chan
  import outpass_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic       UserCLK,
  input  logic       UserRST,
  input  logic       CE,
  input  logic       dIn,
  input  logic [1:0] mode,
  output logic       dOut
);

  logic [DEPTH-1:0] sChainQ, sChainD;
  logic             edgeQ, edgeD;
  logic             selOdd, selHi;
  logic             muxLo, muxHi;

  // Registers advance in every mode so a mode switch shows live contents at once.
  always_comb begin
    sChainD = sChainQ;
    edgeD   = edgeQ;
    if (CE) begin
      sChainD = {sChainQ[DEPTH-2:0], dIn};
      edgeD   = dIn & ~sChainQ[0];
    end
  end

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      sChainQ <= '0;
      edgeQ   <= 1'b0;
    end else begin
      sChainQ <= sChainD;
      edgeQ   <= edgeD;
    end
  end

  // First level picks within a pair (BYPASS/REG, DELAY/EDGE); second level picks the pair.
  assign selOdd = (mode == MODE_REG) || (mode == MODE_EDGE);
  assign selHi  = (mode == MODE_DELAY) || (mode == MODE_EDGE);

  cus_mux21 uMuxLo (
    .A0(dIn),
    .A1(sChainQ[0]),
    .S (selOdd),
    .X (muxLo)
  );

  cus_mux21 uMuxHi (
    .A0(sChainQ[DEPTH-1]),
    .A1(edgeQ),
    .S (selOdd),
    .X (muxHi)
  );

  cus_mux21 uMuxOut (
    .A0(muxLo),
    .A1(muxHi),
    .S (selHi),
    .X (dOut)
  );

endmodule

// File: rtl/outpass_n_frame_config_mux.sv
// WIDTH independent output-pass channels, each configured by two frame config bits.
// Ports:
//   UserCLK    - single clock (EXTERNAL, SHARED_PORT)
//   UserRST    - synchronous active-high reset (EXTERNAL, SHARED_PORT)
//   I          - fabric-side data from the switch matrix
//   CE         - clock enable for all channel registers
//   O          - data to top level (EXTERNAL)
//   ConfigBits - frame config, bits [2k+1:2k] = mode of channel k (GLOBAL)
(* FABulous, BelMap, C0_mode0=0, C0_mode1=1, C1_mode0=2, C1_mode1=3 *)
(* C2_mode0=4, C2_mode1=5, C3_mode0=6, C3_mode1=7 *)
(* C4_mode0=8, C4_mode1=9, C5_mode0=10, C5_mode1=11 *)
(* C6_mode0=12, C6_mode1=13, C7_mode0=14, C7_mode1=15 *)
module outpass_n_frame_config_mux
  import outpass_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned NoConfigBits = 16
) (
  input  logic                    UserCLK,    // EXTERNAL // SHARED_PORT
  input  logic                    UserRST,    // EXTERNAL // SHARED_PORT
  input  logic [WIDTH-1:0]        I,
  input  logic                    CE,
  output logic [WIDTH-1:0]        O,          // EXTERNAL
  input  logic [NoConfigBits-1:0] ConfigBits  // GLOBAL
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : gen_bad_depth
    $error("outpass_n_frame_config_mux: DEPTH out of range");
  end

  if (NoConfigBits != 2 * WIDTH) begin : gen_bad_cfg
    $error("outpass_n_frame_config_mux: NoConfigBits must equal 2*WIDTH");
  end

  for (genvar k = 0; k < WIDTH; k++) begin : gen_chan
    outpass_chan #(
      .DEPTH(DEPTH)
    ) uChan (
      .UserCLK(UserCLK),
      .UserRST(UserRST),
      .CE     (CE),
      .dIn    (I[k]),
      .mode   (ConfigBits[2*k+1:2*k]),
      .dOut   (O[k])
    );
  end

endmodule

// File: tb/tb_outpass_n_frame_config_mux.sv
module tb_outpass_n_frame_config_mux;
  import outpass_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned NC = 8;

  logic          UserCLK = 1'b0;
  logic          UserRST = 1'b1;
  logic [W-1:0]  I = '0;
  logic          CE = 1'b1;
  logic [W-1:0]  O;
  logic [NC-1:0] ConfigBits = '0;

  outpass_n_frame_config_mux #(
    .WIDTH       (W),
    .DEPTH       (D),
    .NoConfigBits(NC)
  ) dut (
    .UserCLK   (UserCLK),
    .UserRST   (UserRST),
    .I         (I),
    .CE        (CE),
    .O         (O),
    .ConfigBits(ConfigBits)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct packed {
    logic [W-1:0] exp;
    logic         chk;
    logic [W-1:0] dmask;
    logic [W-1:0] dval;
  } sb_t;

  sb_t   sb_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Behavioural reference state per channel.
  logic [D-1:0]  m_s[W];
  logic          m_e[W];
  logic          m_valid = 1'b0;
  logic [W-1:0]  p_i = '0;
  logic          p_ce = 1'b1;
  logic          p_rst = 1'b1;

  function automatic logic [NC-1:0] cfg4(input logic [1:0] m0, input logic [1:0] m1,
                                          input logic [1:0] m2, input logic [1:0] m3);
    return {m3, m2, m1, m0};
  endfunction

  task automatic model_edge();
    for (int k = 0; k < W; k++) begin
      if (p_rst) begin
        m_s[k] = '0;
        m_e[k] = 1'b0;
      end else if (p_ce) begin
        m_e[k] = p_i[k] & ~m_s[k][0];
        m_s[k] = {m_s[k][D-2:0], p_i[k]};
      end
    end
    if (p_rst) m_valid = 1'b1;
  endtask

  function automatic logic [W-1:0] model_out(input logic [W-1:0] iv, input logic [NC-1:0] cfg);
    logic [W-1:0] r;
    logic [1:0]   md;
    r = '0;
    for (int k = 0; k < W; k++) begin
      md = cfg[2*k +: 2];
      case (md)
        MODE_BYPASS: r[k] = iv[k];
        MODE_REG:    r[k] = m_s[k][0];
        MODE_DELAY:  r[k] = m_s[k][D-1];
        default:     r[k] = m_e[k];
      endcase
    end
    return r;
  endfunction

  // Drive one cycle of stimulus and queue the expectations for that cycle.
  task automatic step(input logic [W-1:0] iv, input logic ce, input logic rst,
                      input logic [NC-1:0] cfg, input logic [W-1:0] dmask,
                      input logic [W-1:0] dval, input string nm);
    sb_t e;
    @(posedge UserCLK);
    #1;
    model_edge();
    I          = iv;
    CE         = ce;
    UserRST    = rst;
    ConfigBits = cfg;
    p_i        = iv;
    p_ce       = ce;
    p_rst      = rst;
    e.exp   = model_out(iv, cfg);
    e.chk   = m_valid;
    e.dmask = dmask;
    e.dval  = dval;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: the output is presented every cycle; sample mid-cycle.
  initial begin
    sb_t   e;
    string nm;
    forever begin
      @(negedge UserCLK);
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        if (e.chk) begin
          tests++;
          if (O !== e.exp) begin
            fails++;
            $display("FAIL model_%s: O=%h expected %h", nm, O, e.exp);
          end
        end
        if (e.dmask != '0) begin
          tests++;
          if ((O & e.dmask) !== e.dval) begin
            fails++;
            $display("FAIL %s: O&%h=%h expected %h", nm, e.dmask, O & e.dmask, e.dval);
          end
        end
      end
    end
  end

  initial begin
    logic [NC-1:0] cB, cRD, cMix, cE2, cD1, cR3, cD3;
    cB   = cfg4(MODE_BYPASS, MODE_BYPASS, MODE_BYPASS, MODE_BYPASS);
    cRD  = cfg4(MODE_REG, MODE_DELAY, MODE_BYPASS, MODE_BYPASS);
    cMix = cfg4(MODE_REG, MODE_DELAY, MODE_EDGE, MODE_BYPASS);
    cE2  = cfg4(MODE_BYPASS, MODE_BYPASS, MODE_EDGE, MODE_BYPASS);
    cD1  = cfg4(MODE_BYPASS, MODE_DELAY, MODE_BYPASS, MODE_BYPASS);
    cR3  = cfg4(MODE_BYPASS, MODE_BYPASS, MODE_BYPASS, MODE_REG);
    cD3  = cfg4(MODE_BYPASS, MODE_BYPASS, MODE_BYPASS, MODE_DELAY);

    // Bypass: O follows I regardless of clock, reset and CE.
    step(4'hA, 1'b1, 1'b1, cB, 4'hF, 4'hA, "byp_rst");
    step(4'hA, 1'b1, 1'b0, cB, 4'hF, 4'hA, "byp_a");
    step(4'h5, 1'b0, 1'b1, cB, 4'hF, 4'h5, "byp_rst_ce0");
    step(4'h5, 1'b1, 1'b0, cB, 4'hF, 4'h5, "byp_5");

    // Reset state: registered modes read 0, bypass channel reads I.
    step(4'h0, 1'b1, 1'b1, cMix, 4'h0, 4'h0, "rst");
    step(4'hF, 1'b1, 1'b0, cMix, 4'hF, 4'h8, "post_rst");

    // REG on ch0, DELAY on ch1, single-cycle pulse.
    step(4'h0, 1'b1, 1'b1, cRD, 4'h0, 4'h0, "rd_rst");
    step(4'h0, 1'b1, 1'b0, cRD, 4'h0, 4'h0, "rd_idle");
    step(4'h3, 1'b1, 1'b0, cRD, 4'h3, 4'h0, "rd_t0");
    step(4'h0, 1'b1, 1'b0, cRD, 4'h3, 4'h1, "rd_t1");
    step(4'h0, 1'b1, 1'b0, cRD, 4'h3, 4'h0, "rd_t2");
    step(4'h0, 1'b1, 1'b0, cRD, 4'h3, 4'h2, "rd_t3");
    step(4'h0, 1'b1, 1'b0, cRD, 4'h3, 4'h0, "rd_t4");

    // EDGE on ch2, input held high 5 cycles: one pulse, none on the fall.
    step(4'h0, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "edge_pre");
    step(4'h4, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "edge_t0");
    step(4'h4, 1'b1, 1'b0, cE2, 4'h4, 4'h4, "edge_t1");
    step(4'h4, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "edge_t2");
    step(4'h4, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "edge_t3");
    step(4'h4, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "edge_t4");
    step(4'h0, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "edge_fall");
    step(4'h0, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "edge_after");

    // EDGE pulse held while CE=0.
    step(4'h4, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "ehold_t0");
    step(4'h4, 1'b0, 1'b0, cE2, 4'h4, 4'h4, "ehold_t1");
    step(4'h4, 1'b1, 1'b0, cE2, 4'h4, 4'h4, "ehold_t2");
    step(4'h0, 1'b1, 1'b0, cE2, 4'h4, 4'h0, "ehold_t3");

    // DELAY ch1: 1,0,1 with a 2-cycle CE stall after the second datum.
    step(4'h0, 1'b1, 1'b1, cD1, 4'h0, 4'h0, "stall_rst");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "stall_t0");
    step(4'h0, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "stall_t1");
    step(4'h2, 1'b0, 1'b0, cD1, 4'h2, 4'h0, "stall_t2");
    step(4'h2, 1'b0, 1'b0, cD1, 4'h2, 4'h0, "stall_t3");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "stall_t4");
    step(4'h0, 1'b1, 1'b0, cD1, 4'h2, 4'h2, "stall_t5");
    step(4'h0, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "stall_t6");
    step(4'h0, 1'b1, 1'b0, cD1, 4'h2, 4'h2, "stall_t7");
    step(4'h0, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "stall_t8");

    // DELAY ch1 full of ones, reset (with CE=0) discards in-flight data.
    step(4'h2, 1'b1, 1'b0, cD1, 4'h0, 4'h0, "drst_f0");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h0, 4'h0, "drst_f1");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h0, 4'h0, "drst_f2");
    step(4'h2, 1'b0, 1'b1, cD1, 4'h2, 4'h2, "drst_r");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "drst_r1");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "drst_r2");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h2, 4'h0, "drst_r3");
    step(4'h2, 1'b1, 1'b0, cD1, 4'h2, 4'h2, "drst_r4");

    // Ch3 REG switched to DELAY mid-stream.
    step(4'h0, 1'b1, 1'b1, cR3, 4'h0, 4'h0, "sw_rst");
    step(4'h8, 1'b1, 1'b0, cR3, 4'h8, 4'h0, "sw_c0");
    step(4'h0, 1'b1, 1'b0, cR3, 4'h8, 4'h8, "sw_c1");
    step(4'h8, 1'b1, 1'b0, cR3, 4'h8, 4'h0, "sw_c2");
    step(4'h8, 1'b1, 1'b0, cR3, 4'h8, 4'h8, "sw_c3");
    step(4'h0, 1'b1, 1'b0, cD3, 4'h8, 4'h0, "sw_c4");
    step(4'h0, 1'b1, 1'b0, cD3, 4'h8, 4'h8, "sw_c5");
    step(4'h8, 1'b1, 1'b0, cD3, 4'h8, 4'h8, "sw_c6");
    step(4'h0, 1'b1, 1'b0, cD3, 4'h8, 4'h0, "sw_c7");
    step(4'h0, 1'b1, 1'b0, cD3, 4'h8, 4'h0, "sw_c8");
    step(4'h0, 1'b1, 1'b0, cD3, 4'h8, 4'h8, "sw_c9");

    // Mixed modes with pseudo-random data, checked against the model only.
    for (int n = 0; n < 40; n++) begin
      step(W'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           NC'($urandom_range(0, 255)), 4'h0, 4'h0, "rand");
    end

    @(negedge UserCLK);
    @(negedge UserCLK);
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/outpass_n_frame_config_mux.md
OUTPASS_N_FRAME_CONFIG_MUX -- requirements
Module: outpass_n_frame_config_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent output channels (1..32).
REQ-002 SHALL have parameter DEPTH, default 3, delay-line length in cycles for mode DELAY (2..8).
REQ-003 SHALL have parameter NoConfigBits, default 16, equal to 2*WIDTH (set manually, not derived).
REQ-004 SHALL have port UserCLK  input  1  single clock; EXTERNAL, SHARED_PORT.
REQ-005 SHALL have port UserRST  input  1  reset, synchronous, active-high; EXTERNAL, SHARED_PORT.
REQ-006 SHALL have port I  input  WIDTH  fabric-side data from the switch matrix.
REQ-007 SHALL have port CE  input  1  clock enable for all channel registers, from the switch matrix.
REQ-008 SHALL have port O  output  WIDTH  data to top level; EXTERNAL.
REQ-009 SHALL have port ConfigBits  input  NoConfigBits  frame config; bits [2k+1:2k] = mode of channel k; GLOBAL, last in the port list.

Function
REQ-010 Each channel k SHALL operate independently on I[k] and O[k] according to its 2-bit mode.
REQ-011 Mode 00 BYPASS: O[k] SHALL equal I[k] combinationally, with zero latency.
REQ-012 Mode 01 REG: O[k] SHALL equal s0, where s0 <= I[k] on each UserCLK edge with CE=1 (1-cycle latency).
REQ-013 Mode 10 DELAY: O[k] SHALL equal s[DEPTH-1] of shift chain s0..s[DEPTH-1], advancing one stage per edge with CE=1 (DEPTH-cycle latency).
REQ-014 Mode 11 EDGE: O[k] SHALL equal register e, where e <= I[k] & ~s0 on each edge with CE=1 (one-cycle pulse, one cycle after the rising edge is sampled).
REQ-015 With CE=0, all registers (s chain, e) SHALL hold their values; BYPASS output is unaffected.
REQ-016 The shift chain and e SHALL update in every mode, independent of the selected mode.
REQ-017 A mode change SHALL take effect combinationally on O[k], with no flush and no extra latency; O[k] immediately shows the newly selected register.
REQ-018 In EDGE mode with I[k] held high and CE=1, O[k] SHALL stay high for exactly one cycle.
REQ-019 In EDGE mode, if CE=0 during the pulse cycle, the pulse SHALL be held until the next edge with CE=1.

Reset
REQ-020 On a UserCLK edge with UserRST=1, all s stages and e SHALL be cleared to 0 in every channel, regardless of CE.
REQ-021 After reset, O[k] SHALL be 0 in modes REG, DELAY and EDGE, and SHALL equal I[k] in BYPASS.
REQ-022 Reset SHALL take priority over CE and data when they occur together.
REQ-023 When reset is asserted mid-delay, all in-flight data SHALL be discarded; the first post-reset datum appears DEPTH cycles after release.
REQ-024 The first EDGE pulse after reset SHALL occur if I[k]=1 at the first enabled edge (s0=0 after reset).

Structure
REQ-025 Package outpass_pkg SHALL hold mode encodings MODE_BYPASS=2'b00, MODE_REG=2'b01, MODE_DELAY=2'b10, MODE_EDGE=2'b11 and the DEPTH bounds.
REQ-026 Sub-module outpass_chan (one channel: shift chain, edge register, 4:1 output select) SHALL be instantiated WIDTH times via generate.
REQ-027 The output select SHALL be built from cus_mux21 instances (two levels per channel) so the timing-critical path uses the custom cell.
REQ-028 The BelMap attribute SHALL list mode bits per channel, e.g. C0_mode0=0, C0_mode1=1, ...
REQ-029 Mixing mode select and sequential logic in one flat always block is forbidden; the registers and the selection SHALL be kept separate.

Verification (WIDTH=4, DEPTH=3)
REQ-030 All channels BYPASS, I=4'hA -> O=4'hA in the same cycle; toggling UserCLK and UserRST leaves O=I.
REQ-031 Ch0 REG, Ch1 DELAY, CE=1, single-cycle 1 pulse on I[1:0] at cycle t -> O[0]=1 at t+1 only, O[1]=1 at t+3 only.
REQ-032 Ch2 EDGE, I[2] rises at t and is held high for 5 cycles -> O[2]=1 only during cycle t+1; no pulse on the falling edge.
REQ-033 Ch1 DELAY, sequence 1,0,1 with CE=0 inserted for 2 cycles after the second datum -> output sequence 1,0,1 stretched by exactly 2 cycles, with no loss and no duplication.
REQ-034 Ch1 DELAY holding 1s, UserRST=1 for one edge -> O[1]=0 on the next cycle; with I[1]=1 held after release, O[1]=1 on the 3rd cycle after release.
REQ-035 Ch3 switched from REG to DELAY mid-stream -> O[3] immediately shows s2 contents; compare against a reference model every cycle.
